// File: rtl/sync_fifo_v2.sv
// sync_fifo_v2: parametrised single-clock FIFO with full-depth extra-bit pointers.
// Ports: clk, reset (async, active-high), clear (sync flush), wr/data_in write side,
// re/data_out/data_valid read side, full/empty/almost_full/almost_empty/count status,
// overflow/underflow sticky error flags (built only when FIFO_ERR_EN is defined).
// FWFT=1 presents the head entry combinationally; FWFT=0 registers it on each accepted read.
module sync_fifo_v2 #(
    parameter int DEPTH    = 256,
    parameter int DWIDTH   = 8,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     wr,
    input  logic                     re,
    input  logic [DWIDTH-1:0]        data_in,
    output logic [DWIDTH-1:0]        data_out,
    output logic                     data_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_L = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_L = (AW+1)'(AE_LEVEL);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic wr_ok, rd_ok;

    // Status is derived from the pointer registers only, never from same-cycle requests.
    assign count        = wr_ptr - rd_ptr;
    assign empty        = wr_ptr == rd_ptr;
    assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign almost_full  = count >= AF_L;
    assign almost_empty = count <= AE_L;
    assign wr_ok        = wr & ~full & ~clear;
    assign rd_ok        = re & ~empty & ~clear;

    always_ff @(posedge clk)
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= data_in;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out   = mem[rd_ptr[AW-1:0]];
            assign data_valid = ~empty;
        end else begin : g_reg
            always_ff @(posedge clk or posedge reset)
                if (reset) begin
                    data_out   <= '0;
                    data_valid <= 1'b0;
                end else begin
                    data_valid <= rd_ok;
                    if (rd_ok) data_out <= mem[rd_ptr[AW-1:0]];
                end
        end
    endgenerate

`ifdef FIFO_ERR_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr & full)  overflow  <= 1'b1;
            if (re & empty) underflow <= 1'b1;
        end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_v2.sv
// tb_sync_fifo_v2: directed and scoreboarded checks of sync_fifo_v2 in both read modes.
module tb_sync_fifo_v2;
`ifdef FIFO_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1, clear = 1'b0, wr = 1'b0, re = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] f_dout, r_dout;
    logic f_dv, r_dv, f_full, r_full, f_empty, r_empty, f_af, r_af, f_ae, r_ae;
    logic [3:0] f_cnt, r_cnt;
    logic f_ovf, r_ovf, f_unf, r_unf;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    sync_fifo_v2 #(.DEPTH(8), .DWIDTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_fwft (
        .clk(clk), .reset(reset), .clear(clear), .wr(wr), .re(re), .data_in(data_in),
        .data_out(f_dout), .data_valid(f_dv), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
        .overflow(f_ovf), .underflow(f_unf));

    sync_fifo_v2 #(.DEPTH(8), .DWIDTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_reg (
        .clk(clk), .reset(reset), .clear(clear), .wr(wr), .re(re), .data_in(data_in),
        .data_out(r_dout), .data_valid(r_dv), .full(r_full), .empty(r_empty),
        .almost_full(r_af), .almost_empty(r_ae), .count(r_cnt),
        .overflow(r_ovf), .underflow(r_unf));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        wr = w;
        re = r;
        data_in = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
        re = 1'b0;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_v, nxt;
        int sent, rcvd, cycles;
        logic w, r, wa, ra;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt", f_cnt, 0);
        chk("rst_cnt_reg", r_cnt, 0);
        chk("rst_empty", f_empty, 1);
        chk("rst_full", f_full, 0);
        chk("rst_ae", f_ae, 1);
        chk("rst_af", f_af, 0);
        chk("rst_fdv", f_dv, 0);
        chk("rst_rdv", r_dv, 0);
        chk("rst_rdout", r_dout, 0);
        chk("rst_ovf", r_ovf, 0);
        chk("rst_unf", r_unf, 0);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 0, 8'(i));
            chk("wr_cnt", f_cnt, i);
            chk("wr_ae", f_ae, i <= 2);
        end
        chk("wr_af", f_af, 0);
        chk("wr_fdv", f_dv, 1);
        for (int i = 1; i <= 4; i++) begin
            chk("rd_fdout", f_dout, i);
            cyc(0, 1, 0);
            chk("rd_rdout", r_dout, i);
            chk("rd_rdv", r_dv, 1);
            chk("rd_cnt", f_cnt, 4 - i);
        end
        chk("rd_empty", f_empty, 1);
        cyc(0, 0, 0);
        chk("idle_rdv", r_dv, 0);
        cyc(0, 1, 0);
        chk("unf_cnt", f_cnt, 0);
        chk("unf_flag", f_unf, ERR);
        chk("unf_rdv", r_dv, 0);
        clear = 1'b1;
        cyc(0, 0, 0);
        clear = 1'b0;
        chk("clr_unf", f_unf, 0);
        for (int k = 1; k <= 8; k++) begin
            cyc(1, 0, 8'(8'h10 + k - 1));
            chk("fill_cnt", f_cnt, k);
            chk("fill_af", f_af, k >= 6);
            chk("fill_full", f_full, k == 8);
        end
        cyc(1, 0, 8'h99);
        chk("ovf_cnt", f_cnt, 8);
        chk("ovf_flag", f_ovf, ERR);
        chk("ovf_head", f_dout, 8'h10);
        cyc(1, 1, 8'h77);
        chk("fwr_cnt", f_cnt, 7);
        chk("fwr_full", f_full, 0);
        chk("fwr_fdout", f_dout, 8'h11);
        chk("fwr_rdout", r_dout, 8'h10);
        chk("fwr_rdv", r_dv, 1);
        for (int k = 1; k <= 7; k++) begin
            chk("drain_fdout", f_dout, 8'h10 + k);
            cyc(0, 1, 0);
        end
        chk("drain_empty", f_empty, 1);
        chk("drain_ovf", f_ovf, ERR);
        cyc(1, 1, 8'h55);
        chk("ewr_cnt", f_cnt, 1);
        chk("ewr_rdv", r_dv, 0);
        chk("ewr_fdout", f_dout, 8'h55);
        chk("ewr_unf", f_unf, ERR);
        cyc(0, 1, 0);
        chk("ewr_rd", r_dout, 8'h55);
        cyc(1, 0, 8'hA5);
        cyc(0, 1, 0);
        chk("reg_dout", r_dout, 8'hA5);
        chk("reg_dv", r_dv, 1);
        cyc(0, 0, 0);
        chk("reg_dv_drop", r_dv, 0);
        chk("reg_hold", r_dout, 8'hA5);
        for (int k = 0; k < 5; k++) cyc(1, 0, 8'(8'h20 + k));
        chk("pre_clr_cnt", f_cnt, 5);
        clear = 1'b1;
        cyc(1, 1, 8'hEE);
        clear = 1'b0;
        chk("clr_cnt", f_cnt, 0);
        chk("clr_empty", f_empty, 1);
        chk("clr_fdv", f_dv, 0);
        chk("clr_rdv", r_dv, 0);
        chk("clr_ovf", f_ovf, 0);
        chk("clr_unf2", f_unf, 0);
        cyc(1, 0, 8'h3C);
        chk("clr_next", f_dout, 8'h3C);
        chk("clr_next_cnt", f_cnt, 1);
        for (int k = 0; k < 4; k++) cyc(1, 0, 8'(8'h30 + k));
        chk("pre_rst_cnt", f_cnt, 5);
        #3 reset = 1'b1;
        #1;
        chk("arst_cnt", f_cnt, 0);
        chk("arst_empty", f_empty, 1);
        chk("arst_full", f_full, 0);
        chk("arst_ae", f_ae, 1);
        chk("arst_rdout", r_dout, 0);
        chk("arst_rdv", r_dv, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(1, 0, 8'h42);
        chk("arst_next", f_dout, 8'h42);
        cyc(0, 1, 0);
        chk("arst_next_reg", r_dout, 8'h42);
        sent = 0;
        rcvd = 0;
        cycles = 0;
        nxt = 8'h00;
        while ((sent < 1000 || rcvd < 1000) && cycles < 20000) begin
            w = (sent < 1000) && ($urandom_range(0, 1) == 1);
            r = $urandom_range(0, 1) == 1;
            wa = w && q.size() != 8;
            ra = r && q.size() != 0;
            exp_v = 8'h00;
            if (ra) begin
                exp_v = q.pop_front();
                chk("str_fdout", f_dout, exp_v);
                rcvd++;
            end
            if (wa) begin
                q.push_back(nxt);
                sent++;
            end
            cyc(w, r, nxt);
            if (wa) nxt = nxt + 8'd1;
            chk("str_cnt", f_cnt, q.size());
            if (ra) chk("str_rdout", r_dout, exp_v);
            chk("str_rdv", r_dv, ra);
            cycles++;
        end
        chk("str_done", rcvd, 1000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sync_fifo_v2.md
# sync_fifo_v2

Parametrised synchronous FIFO, successor to the UART byte FIFO, for the UART TX/RX paths and any other single-clock buffering in the design. It uses the full DEPTH entries, with extra-bit pointers instead of the one-slot-empty scheme. It adds programmable almost-full/almost-empty thresholds, a synchronous flush, and two read modes: first-word-fall-through and registered. Optional sticky overflow/underflow error flags are compiled in by macro.

## Interface
- DEPTH, 256: number of entries; power of two, ≥ 2
- DWIDTH, 8: data width in bits
- AF_LEVEL, DEPTH-4: almost_full asserts when count ≥ AF_LEVEL
- AE_LEVEL, 4: almost_empty asserts when count ≤ AE_LEVEL
- FWFT, 1: 1 = first-word-fall-through read; 0 = registered read
- clk  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous flush; priority over wr/re
- wr  in  1  write request
- re  in  1  read request
- data_in  in  DWIDTH  write data
- data_out  out  DWIDTH  read data
- data_valid  out  1  data_out holds valid data (meaning depends on mode)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty

## Operation
- Pointers wr_ptr and rd_ptr are AW+1 bits wide, where AW = $clog2(DEPTH). The low AW bits address memory.
- Flags and count:
  - count = wr_ptr − rd_ptr, modulo 2^(AW+1).
  - empty = (wr_ptr == rd_ptr).
  - full = low bits equal and MSBs differ.
  - All flags and count are combinational from the pointer registers only. They never depend on the same-cycle wr or re.
- Acceptance: a write is accepted iff wr & ~full & ~clear; a read is accepted iff re & ~empty & ~clear. Both use the flags sampled before the edge.
- Full with wr & re: the read is accepted and the write is rejected. count goes to DEPTH−1.
- Empty with wr & re: the write is accepted and the read is rejected. count goes to 1.
- Otherwise, a simultaneous accepted write and read leaves count unchanged.
- Wrap: pointers increment modulo 2^(AW+1) with no special case. Occupancy is correct across any number of wraps.
- Memory is not reset or cleared. Only pointers, output register and flags are.
- FWFT=1:
  - data_out = mem[rd_ptr[AW-1:0]], combinational.
  - data_valid = ~empty.
  - data_out is don't-care while empty.
- FWFT=0:
  - On an accepted read, data_out <= mem[rd_ptr] at that edge.
  - data_valid pulses high for exactly one cycle after each accepted read.
  - data_out holds its value otherwise.
- clear: at the next edge, wr_ptr = rd_ptr = 0, data_valid = 0, and the sticky flags are cleared. wr and re are ignored in that cycle.
- Reset (asserted at any time, including mid-transfer):
  - Pointers 0, data_out 0, data_valid 0, overflow/underflow 0.
  - Therefore empty=1, full=0, almost_empty=1, almost_full=0 (for AF_LEVEL ≥ 1), count=0.

## Timing
- Write latency: data written at edge N is visible at data_out from edge N in FWFT mode (empty drops after N). It can be requested by re in the cycle after N.
- Registered read latency: re accepted at edge N → data_out and data_valid are valid after edge N, for one cycle.
- Flags update one edge after the accepted operation that changes them. There is no look-ahead.
- Throughput is one write and one read per cycle, sustained.
- Reset is asynchronous on assertion. De-assertion must be synchronised externally to clk.

## Configuration
- FIFO_ERR_EN defined:
  - overflow sets on any cycle with wr & full & ~clear.
  - underflow sets on any cycle with re & empty & ~clear.
  - Both hold until reset or clear.
- FIFO_ERR_EN undefined: overflow and underflow are tied to 0 and no error logic is built. The ports remain present.

## Test plan
- Reset, then write 0x01..0x04 (DEPTH=8, AF=6, AE=2) → count=4, almost_empty=0. FWFT reads return 0x01..0x04 in order, then empty=1.
- Fill 8 entries → full=1, almost_full=1 at count 6. A 9th write is rejected, count stays 8, and overflow=1 (with FIFO_ERR_EN).
- Full plus simultaneous wr & re → count=7 and the head entry is popped. Empty plus simultaneous wr & re → count=1 and the read is ignored.
- Stream 1000 incrementing bytes with random wr/re gaps (DEPTH=8) → output is an identical sequence across multiple pointer wraps, and count always matches the scoreboard.
- FWFT=0: write 0xA5, assert re at edge N → data_out=0xA5 and data_valid=1 exactly one cycle after N.
- Assert reset mid-stream with count=5, and separately pulse clear with count=5 → count=0, empty=1, data_valid=0, sticky flags 0. The next written word is read back first.
